// File: rtl/audio_frame_fifo.sv
// Multi-channel audio frame buffer between the CDC stage and the serializer.
// Frames are pushed on tick_in and popped on req_in. One producer request
// (req_out) is kept in flight while there is room. Underrun and overflow are
// reported as sticky flags, which are cleared each time playback starts.
module audio_frame_fifo #(
  parameter int DATA_W        = 24,
  parameter int CHANNELS      = 2,
  parameter int DEPTH         = 4,
  parameter int UNDERRUN_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         play_in,
  input  logic                         tick_in,
  input  logic [CHANNELS*DATA_W-1:0]   audio_in,
  output logic                         req_out,
  input  logic                         req_in,
  output logic [CHANNELS*DATA_W-1:0]   audio_out,
  output logic                         tick_out,
  output logic                         play_out,
  output logic [$clog2(DEPTH+1)-1:0]   level_out,
  output logic                         underrun_out,
  output logic                         overflow_out
);

  localparam int FW = CHANNELS * DATA_W;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [FW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          outstanding;
  logic [FW-1:0] last_frame;

  logic          active;
  logic          push_ev;
  logic          pop_ev;
  logic          push_ok;
  logic          pop_ok;
  logic          underrun_ev;
  logic          overflow_ev;
  logic          outst_eff;
  logic          req_fire;
  logic [LW-1:0] level_nxt;

  assign level_out = level;

  // Event decode for this cycle. Events also require play_in so that a
  // request arriving on the same edge that play_out falls is dropped.
  always_comb begin
    active      = play_in & play_out;
    push_ev     = active & tick_in;
    pop_ev      = active & req_in;
    pop_ok      = pop_ev & (level != '0);
    underrun_ev = pop_ev & (level == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then.
    push_ok     = push_ev & ((level != FULL_LVL) | pop_ok);
    overflow_ev = push_ev & ~push_ok;
    level_nxt   = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_nxt = level - LW'(1);
    end
    // Any arriving frame, whether stored or dropped, answers the request.
    outst_eff = outstanding & ~push_ev;
    req_fire  = active & ~outst_eff & (level_nxt < FULL_LVL);
  end

  // Frame storage; written only when a push is accepted.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem[wr_ptr] <= audio_in;
    end
  end

  // Control, pointers, flags and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      play_out     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      outstanding  <= 1'b0;
      last_frame   <= '0;
      req_out      <= 1'b0;
      tick_out     <= 1'b0;
      audio_out    <= '0;
      underrun_out <= 1'b0;
      overflow_out <= 1'b0;
    end else if (!play_in) begin
      // Stopping or idle: FIFO flushed, outputs zeroed, flags kept.
      play_out    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      outstanding <= 1'b0;
      req_out     <= 1'b0;
      tick_out    <= 1'b0;
      audio_out   <= '0;
    end else if (!play_out) begin
      // Playback starting: clear the sticky flags as play_out rises.
      play_out     <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      outstanding  <= 1'b0;
      req_out      <= 1'b0;
      tick_out     <= 1'b0;
      audio_out    <= '0;
      underrun_out <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr     <= rd_ptr + PW'(1);
        audio_out  <= mem[rd_ptr];
        last_frame <= mem[rd_ptr];
      end else if (underrun_ev) begin
        audio_out <= (UNDERRUN_MODE != 0) ? last_frame : '0;
      end
      level       <= level_nxt;
      outstanding <= req_fire | outst_eff;
      req_out     <= req_fire;
      tick_out    <= pop_ev;
      if (underrun_ev) begin
        underrun_out <= 1'b1;
      end
      if (overflow_ev) begin
        overflow_out <= 1'b1;
      end
    end
  end

endmodule

// File: doc/audio_frame_fifo.md
# audio_frame_fifo

Parametrised multi-channel audio frame buffer for the audioport output path, placed in the mclk domain between the clock-domain-crossing stage and the serializer. It accepts complete frames (one sample per channel) on a tick strobe, requests replacement frames from the producer with a single-outstanding req/tick handshake, and delivers frames to the serializer on demand. It also detects underrun and overflow, with a configurable underrun fill policy.

## Interface
Parameters:
- DATA_W, 24, bits per channel sample
- CHANNELS, 2, channels per frame (1..8)
- DEPTH, 4, frame slots; power of two, 2..16
- UNDERRUN_MODE, 0, 0 = output zero frame on underrun, 1 = repeat last delivered frame

Ports:
- clk  in  1  clock (mclk domain)
- rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
- play_in  in  1  play enable from upstream
- tick_in  in  1  one-cycle strobe: audio_in holds a valid frame
- audio_in  in  CHANNELS*DATA_W  frame in; channel 0 in bits [DATA_W-1:0]
- req_out  out  1  one-cycle request to producer for next frame
- req_in  in  1  one-cycle frame request from serializer
- audio_out  out  CHANNELS*DATA_W  delivered frame; same packing as audio_in
- tick_out  out  1  one-cycle strobe: audio_out updated
- play_out  out  1  registered play_in
- level_out  out  $clog2(DEPTH+1)  stored frame count
- underrun_out  out  1  sticky underrun flag
- overflow_out  out  1  sticky overflow flag

## Operation
- Reset (rst_n=0 at an edge) clears all outputs to 0, empties the FIFO (pointers 0, level 0), clears the outstanding-request flag, and clears the last-frame register. This applies mid-operation as well; no partial frame survives.
- play_out is play_in registered once. All of the following use play_out as "active".
- Inactive (play_out=0):
  - FIFO held flushed; tick_in and req_in ignored.
  - req_out=0 and tick_out=0; audio_out forced to 0.
  - Sticky flags hold their value.
- Activation (play_out 0→1 edge, detected internally): underrun_out and overflow_out cleared in that cycle.
- Push: tick_in=1 while active.
  - Not full: frame written at wr_ptr, wr_ptr+1 mod DEPTH, outstanding flag cleared.
  - Full with no pop in the same cycle: frame dropped, overflow_out←1, outstanding flag cleared.
- Pop: req_in=1 while active.
  - level>0: head frame registered to audio_out and to the last-frame register, rd_ptr+1 mod DEPTH, tick_out=1 next cycle.
  - level=0 (underrun): underrun_out←1, tick_out=1 next cycle. audio_out = 0 (UNDERRUN_MODE=0) or the last-frame register (UNDERRUN_MODE=1).
- Simultaneous push and pop:
  - Level unchanged; both pointers advance.
  - Full: push accepted, because the pop frees a slot in the same cycle.
  - Empty: no bypass. The pop is an underrun and the pushed frame is stored (level becomes 1).
- Request generation: req_out pulses for one cycle when active, outstanding=0, and level (after this cycle's push/pop) < DEPTH. Outstanding←1 on that pulse. At most one request is in flight at a time.
- level_out equals the internal occupancy count; never exceeds DEPTH.

## Timing
- play_in → play_out: 1 cycle.
- req_in → tick_out/audio_out: 1 cycle; audio_out holds until the next tick_out or inactivity.
- First req_out after activation: the cycle after play_out rises (level 0, outstanding 0).
- tick_in → next req_out: 1 cycle, if not full after the push.
- Pop from full with outstanding=0 → req_out: 1 cycle.
- Push and pop updates to level_out are visible the cycle after the event.
- play_in falling: flush and output zeroing take effect in the cycle play_out falls. A req_in coincident with that edge is ignored.

## Test plan
- Reset/idle:
  - Stimulus: rst_n low 3 cycles, then play_in=0 for 10 cycles with random tick_in/req_in.
  - Response: all outputs 0, level_out=0, no req_out.
- Fill and drain (CHANNELS=2, DEPTH=4):
  - Stimulus: play_in=1; answer each req_out with tick_in after 2 cycles, frames {0x000001,0x100001}..{0x000004,0x100004}; then 4 req_in pulses.
  - Response: level_out reaches 4, req_out stops at full. Frames are delivered in order, each with tick_out one cycle after req_in, and req_out reissues after the first pop.
- Underrun, both modes:
  - Stimulus: a single stored frame {0xABCDEF,0x123456}, then two req_in pulses.
  - Response: the second delivery is 0 in mode 0, or {0xABCDEF,0x123456} again in mode 1; underrun_out=1 in both.
- Overflow:
  - Stimulus: with level_out=4, an unsolicited tick_in with no req_in.
  - Response: frame dropped, overflow_out=1, level_out stays 4.
- Simultaneous events:
  - Stimulus: push+pop in the same cycle, once at full and once at empty.
  - Response: at full, level stays 4 and no overflow. At empty, underrun_out=1 and level_out becomes 1.
- Play toggle:
  - Stimulus: play_in drops with level_out=3, then rises again.
  - Response: level_out→0, audio_out→0 once play_out falls; sticky flags cleared when play_out rises; req_out one cycle after play_out rises.
